// File: rtl/instr_mem_loader_if.sv
// Loader-side bus: programming handshake from the host plus the processor fetch port.
// The loader connects through the slave modport; the driver side uses master.
interface instr_mem_loader_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 3
);
  logic              load_start;
  logic              run_start;
  logic              wr_valid;
  logic              wr_last;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] instr;
  logic              cpu_run;
  logic              load_done;

  modport master (
    output load_start, run_start, wr_valid, wr_last, wr_data, pc,
    input  wr_ready, wr_addr, instr, cpu_run, load_done
  );

  modport slave (
    input  load_start, run_start, wr_valid, wr_last, wr_data, pc,
    output wr_ready, wr_addr, instr, cpu_run, load_done
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Instruction memory with a streaming loader: words are written sequentially from
// address 0, then the processor is released with a combinational fetch port.
module instr_mem_loader #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  instr_mem_loader_if.slave   bus
);
  localparam int              DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic                load_done_q, load_done_d;
  logic                wr_en;
  logic [DEPTH-1:0]    wr_sel;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_addr_q   <= '0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      load_done_q <= load_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    load_done_d = 1'b0;
    wr_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          state_d   = LOAD;
          wr_addr_d = '0;
        end else if (bus.run_start) begin
          state_d = RUN;
        end
      end
      LOAD: begin
        // A restart request wins over a word presented in the same cycle.
        if (bus.load_start) begin
          wr_addr_d = '0;
        end else if (bus.wr_valid) begin
          wr_en = 1'b1;
          if (bus.wr_last || (wr_addr_q == LAST_ADDR)) begin
            state_d     = RUN;
            wr_addr_d   = '0;
            load_done_d = 1'b1;
          end else begin
            wr_addr_d = wr_addr_q + 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.load_start) begin
          state_d   = LOAD;
          wr_addr_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        wr_addr_d = '0;
      end
    endcase
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
    assign wr_sel[gi] = wr_en && (wr_addr_q == ADDR_W'(gi));
  end

  // Flop-based storage: the whole array must clear on reset, which block RAM cannot do.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset) begin
        mem_q[i] <= '0;
      end else if (wr_sel[i]) begin
        mem_q[i] <= bus.wr_data;
      end
    end
  end

  assign bus.wr_ready  = (state_q == LOAD);
  assign bus.cpu_run   = (state_q == RUN);
  assign bus.wr_addr   = wr_addr_q;
  assign bus.load_done = load_done_q;
  assign bus.instr     = mem_q[bus.pc];
endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed scenarios plus a random run,
// all checked against a behavioural model of the loader kept in the bench.
module tb_instr_mem_loader;
  logic clk = 1'b0;
  logic reset = 1'b1;

  instr_mem_loader_if #(.DATA_W(12), .ADDR_W(3)) bus ();

  instr_mem_loader #(.DATA_W(12), .ADDR_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: mode flags, write pointer, done pulse and the memory image.
  bit          m_loading, m_running, m_done;
  logic [2:0]  m_addr;
  logic [11:0] m_mem [8];

  task automatic model_edge();
    if (reset) begin
      m_loading = 0; m_running = 0; m_done = 0; m_addr = 0;
      for (int i = 0; i < 8; i++) m_mem[i] = 12'h000;
    end else begin
      m_done = 0;
      if (m_loading) begin
        if (bus.load_start) m_addr = 0;
        else if (bus.wr_valid) begin
          m_mem[m_addr] = bus.wr_data;
          if (bus.wr_last || m_addr == 3'd7) begin
            m_loading = 0; m_running = 1; m_addr = 0; m_done = 1;
          end else m_addr = m_addr + 3'd1;
        end
      end else if (m_running) begin
        if (bus.load_start) begin m_running = 0; m_loading = 1; m_addr = 0; end
      end else begin
        if (bus.load_start) begin m_loading = 1; m_addr = 0; end
        else if (bus.run_start) m_running = 1;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.load_start = 0; bus.run_start = 0; bus.wr_valid = 0;
    bus.wr_last = 0; bus.wr_data = '0; bus.pc = '0;
  endtask

  task automatic test_reset();
    reset = 1;
    tick();
    reset = 0;
    for (int p = 0; p < 8; p++) begin
      bus.pc = 3'(p);
      #1;
      vectors++;
      if (bus.instr !== 12'h000) begin
        miscompares++;
        $display("FAIL reset_instr pc=%0d: got %h expected 000", p, bus.instr);
      end
    end
    vectors++;
    if (bus.cpu_run !== 1'b0 || bus.wr_ready !== 1'b0 || bus.wr_addr !== 3'd0 || bus.load_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got run=%b rdy=%b addr=%0d done=%b expected 0 0 0 0",
               bus.cpu_run, bus.wr_ready, bus.wr_addr, bus.load_done);
    end
    tick();
    vectors++;
    if (bus.cpu_run !== 1'b0 || bus.wr_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_hold: got run=%b rdy=%b expected 0 0", bus.cpu_run, bus.wr_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_full_load();
    logic [11:0] w [8];
    int done_pulses = 0;
    w = '{12'h000, 12'h011, 12'h281, 12'h6C1, 12'h901, 12'hB41, 12'h434, 12'h559};
    bus.load_start = 1;
    tick();
    bus.load_start = 0;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (bus.wr_ready !== 1'b1 || bus.wr_addr !== 3'(i)) begin
        miscompares++;
        $display("FAIL full_load_addr word %0d: got rdy=%b addr=%0d expected 1 %0d",
                 i, bus.wr_ready, bus.wr_addr, i);
      end
      bus.wr_valid = 1; bus.wr_data = w[i]; bus.wr_last = 0;
      tick();
      if (bus.load_done === 1'b1) done_pulses++;
    end
    bus.wr_valid = 0;
    vectors++;
    if (bus.load_done !== 1'b1 || bus.cpu_run !== 1'b1 || bus.wr_addr !== 3'd0 || bus.wr_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL full_load_end: got done=%b run=%b addr=%0d rdy=%b expected 1 1 0 0",
               bus.load_done, bus.cpu_run, bus.wr_addr, bus.wr_ready);
    end
    tick();
    if (bus.load_done === 1'b1) done_pulses++;
    vectors++;
    if (done_pulses != 1) begin
      miscompares++;
      $display("FAIL full_load_pulses: got %0d expected 1", done_pulses);
    end
    for (int p = 0; p < 8; p++) begin
      bus.pc = 3'(p);
      #1;
      vectors++;
      if (bus.instr !== w[p]) begin
        miscompares++;
        $display("FAIL full_load_readback pc=%0d: got %h expected %h", p, bus.instr, w[p]);
      end
    end
    $display("test_full_load done");
  endtask

  task automatic test_early_stop();
    logic [11:0] d [3];
    reset = 1;
    tick();
    reset = 0;
    bus.load_start = 1;
    tick();
    bus.load_start = 0;
    for (int i = 0; i < 3; i++) begin
      d[i] = 12'($urandom);
      bus.wr_valid = 1; bus.wr_data = d[i]; bus.wr_last = (i == 2);
      tick();
    end
    bus.wr_valid = 0; bus.wr_last = 0;
    vectors++;
    if (bus.cpu_run !== 1'b1 || bus.wr_addr !== 3'd0 || bus.load_done !== 1'b1) begin
      miscompares++;
      $display("FAIL early_stop_ctrl: got run=%b addr=%0d done=%b expected 1 0 1",
               bus.cpu_run, bus.wr_addr, bus.load_done);
    end
    for (int p = 0; p < 8; p++) begin
      bus.pc = 3'(p);
      #1;
      vectors++;
      if (bus.instr !== ((p < 3) ? d[p] : 12'h000)) begin
        miscompares++;
        $display("FAIL early_stop_mem pc=%0d: got %h expected %h", p, bus.instr,
                 (p < 3) ? d[p] : 12'h000);
      end
    end
    $display("test_early_stop done");
  endtask

  task automatic test_restart();
    logic [11:0] old4, blocked, fresh;
    old4 = m_mem[4];
    bus.load_start = 1;
    tick();
    bus.load_start = 0;
    for (int i = 0; i < 4; i++) begin
      bus.wr_valid = 1; bus.wr_data = 12'($urandom);
      tick();
    end
    vectors++;
    if (bus.wr_addr !== 3'd4) begin
      miscompares++;
      $display("FAIL restart_pre_addr: got %0d expected 4", bus.wr_addr);
    end
    do blocked = 12'($urandom); while (blocked == old4);
    bus.load_start = 1; bus.wr_valid = 1; bus.wr_data = blocked;
    tick();
    bus.load_start = 0; bus.wr_valid = 0;
    bus.pc = 3'd4;
    #1;
    vectors++;
    if (bus.instr !== old4 || bus.wr_addr !== 3'd0 || bus.wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_nowrite: got mem4=%h addr=%0d rdy=%b expected %h 0 1",
               bus.instr, bus.wr_addr, bus.wr_ready, old4);
    end
    fresh = 12'($urandom);
    bus.wr_valid = 1; bus.wr_data = fresh; bus.wr_last = 1;
    tick();
    bus.wr_valid = 0; bus.wr_last = 0;
    bus.pc = 3'd0;
    #1;
    vectors++;
    if (bus.instr !== fresh || bus.cpu_run !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_landing: got mem0=%h run=%b expected %h 1", bus.instr, bus.cpu_run, fresh);
    end
    $display("test_restart done");
  endtask

  task automatic test_reload_from_run();
    logic [11:0] snap [8];
    for (int p = 0; p < 8; p++) snap[p] = m_mem[p];
    bus.wr_valid = 1; bus.wr_last = 1; bus.wr_data = ~snap[0];
    tick();
    bus.wr_valid = 0; bus.wr_last = 0;
    for (int p = 0; p < 8; p++) begin
      bus.pc = 3'(p);
      #1;
      vectors++;
      if (bus.instr !== snap[p]) begin
        miscompares++;
        $display("FAIL run_nowrite pc=%0d: got %h expected %h", p, bus.instr, snap[p]);
      end
    end
    bus.load_start = 1; bus.run_start = 1;
    tick();
    bus.load_start = 0; bus.run_start = 0;
    vectors++;
    if (bus.cpu_run !== 1'b0 || bus.wr_ready !== 1'b1 || bus.wr_addr !== 3'd0) begin
      miscompares++;
      $display("FAIL reload_from_run: got run=%b rdy=%b addr=%0d expected 0 1 0",
               bus.cpu_run, bus.wr_ready, bus.wr_addr);
    end
    $display("test_reload_from_run done");
  endtask

  task automatic test_reset_mid_load();
    bus.load_start = 1;
    tick();
    bus.load_start = 0;
    for (int i = 0; i < 5; i++) begin
      bus.wr_valid = 1; bus.wr_data = 12'($urandom) | 12'h001;
      tick();
    end
    vectors++;
    if (bus.wr_addr !== 3'd5) begin
      miscompares++;
      $display("FAIL mid_load_addr: got %0d expected 5", bus.wr_addr);
    end
    reset = 1; bus.load_start = 1; bus.wr_data = 12'hFFF;
    tick();
    reset = 0; bus.load_start = 0; bus.wr_valid = 0;
    for (int p = 0; p < 8; p++) begin
      bus.pc = 3'(p);
      #1;
      vectors++;
      if (bus.instr !== 12'h000) begin
        miscompares++;
        $display("FAIL mid_load_reset_mem pc=%0d: got %h expected 000", p, bus.instr);
      end
    end
    vectors++;
    if (bus.cpu_run !== 1'b0 || bus.wr_ready !== 1'b0 || bus.wr_addr !== 3'd0) begin
      miscompares++;
      $display("FAIL mid_load_reset_ctrl: got run=%b rdy=%b addr=%0d expected 0 0 0",
               bus.cpu_run, bus.wr_ready, bus.wr_addr);
    end
    bus.run_start = 1;
    tick();
    bus.run_start = 0;
    bus.pc = 3'($urandom);
    #1;
    vectors++;
    if (bus.cpu_run !== 1'b1 || bus.instr !== 12'h000) begin
      miscompares++;
      $display("FAIL run_after_reset: got run=%b instr=%h expected 1 000", bus.cpu_run, bus.instr);
    end
    $display("test_reset_mid_load done");
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      reset          = ($urandom_range(0, 59) == 0);
      bus.load_start = ($urandom_range(0, 11) == 0);
      bus.run_start  = ($urandom_range(0, 5) == 0);
      bus.wr_valid   = $urandom_range(0, 1) == 1;
      bus.wr_last    = ($urandom_range(0, 4) == 0);
      bus.wr_data    = 12'($urandom);
      bus.pc         = 3'($urandom);
      #1;
      vectors++;
      if (bus.instr !== m_mem[bus.pc]) begin
        miscompares++;
        $display("FAIL random_pre_instr cycle %0d pc=%0d: got %h expected %h",
                 n, bus.pc, bus.instr, m_mem[bus.pc]);
      end
      tick();
      reset = 0;
      vectors++;
      if (bus.wr_ready !== m_loading || bus.cpu_run !== m_running ||
          bus.wr_addr !== m_addr || bus.load_done !== m_done || bus.instr !== m_mem[bus.pc]) begin
        miscompares++;
        $display("FAIL random_cycle %0d: got rdy=%b run=%b addr=%0d done=%b instr=%h expected %b %b %0d %b %h",
                 n, bus.wr_ready, bus.cpu_run, bus.wr_addr, bus.load_done, bus.instr,
                 m_loading, m_running, m_addr, m_done, m_mem[bus.pc]);
      end
    end
    $display("test_random done");
  endtask

  initial begin
    clear_inputs();
    m_loading = 0; m_running = 0; m_done = 0; m_addr = 0;
    for (int i = 0; i < 8; i++) m_mem[i] = 12'h000;
    test_reset();
    test_full_load();
    test_early_stop();
    test_restart();
    test_reload_from_run();
    reset = 1;
    tick();
    reset = 0;
    test_reset_mid_load();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 12, meaning the instruction word width.
REQ-002 SHALL have parameter ADDR_W, default 3, meaning the address width; depth is 2**ADDR_W (8).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port load_start, input, 1, request to (re)start programming at address 0.
REQ-006 SHALL have port run_start, input, 1, request to release the processor without loading.
REQ-007 SHALL have port wr_valid, input, 1, meaning wr_data holds a word to store.
REQ-008 SHALL have port wr_last, input, 1, qualified by wr_valid, meaning the current word is the final one.
REQ-009 SHALL have port wr_data, input, DATA_W, the instruction word to store.
REQ-010 SHALL have port wr_ready, output, 1, meaning the loader accepts a word this cycle.
REQ-011 SHALL have port wr_addr, output, ADDR_W, the address the next accepted word is written to.
REQ-012 SHALL have port pc, input, ADDR_W, the processor fetch address.
REQ-013 SHALL have port instr, output, DATA_W, the instruction word at pc.
REQ-014 SHALL have port cpu_run, output, 1, the processor enable.
REQ-015 SHALL have port load_done, output, 1, a one-cycle pulse when loading completes.

Function
REQ-016 SHALL implement the FSM states IDLE, LOAD and RUN; outputs are registered or decoded from state only, except instr.
REQ-017 SHALL compute instr = mem[pc] combinationally in every state.
REQ-018 SHALL make a write to mem visible on instr from the cycle after the accepting edge; the accepting cycle shows the old word.
REQ-019 SHALL drive wr_ready=1 only in LOAD and cpu_run=1 only in RUN.
REQ-020 SHALL, in IDLE, go to LOAD on load_start, else go to RUN on run_start, else stay in IDLE.
REQ-021 SHALL, on entry to LOAD from any state, set wr_addr=0.
REQ-022 SHALL accept a word on a cycle with LOAD, wr_valid=1 and load_start=0; mem[wr_addr] gets wr_data at that edge.
REQ-023 SHALL, on acceptance with wr_last=0 and wr_addr<2**ADDR_W-1, increment wr_addr and stay in LOAD.
REQ-024 SHALL, on acceptance with wr_last=1 or wr_addr=2**ADDR_W-1, go to RUN, set wr_addr=0 (wrap) and assert load_done for exactly the next cycle.
REQ-025 SHALL leave entries above the last written address unchanged on early termination by wr_last.
REQ-026 SHALL, if load_start=1 in LOAD, restart: set wr_addr=0, stay in LOAD, and not perform a concurrent wr_valid write.
REQ-027 SHALL, if load_start=1 in RUN, go to LOAD (cpu_run=0 next cycle); run_start is ignored outside IDLE.
REQ-028 SHALL give load_start priority over run_start when both are asserted in IDLE.
REQ-029 SHALL ignore wr_valid and wr_last outside LOAD; mem is not modified.

Reset
REQ-030 SHALL, on a clock edge with reset=1, set state=IDLE, wr_addr=0, cpu_run=0, wr_ready=0 and load_done=0.
REQ-031 SHALL, on the same reset edge, clear all mem entries to 0, so instr=0 for every pc.
REQ-032 SHALL give reset priority over all other inputs, including mid-LOAD and mid-RUN; no write occurs on a reset edge.

Verification
REQ-033 SHALL check reset then idle: after reset, instr=0 for pc=0..7, cpu_run=0, wr_ready=0 and wr_addr=0.
REQ-034 SHALL check a full load: load_start, then 8 accepted words 12'h000,12'h011,12'h281,12'h6C1,12'h901,12'hB41,12'h434,12'h559 -> load_done pulses once, cpu_run=1, and pc=0..7 reads back the same sequence.
REQ-035 SHALL check an early stop: load 3 words with wr_last on the 3rd -> RUN, wr_addr=0, entries 3..7 unchanged (0 after reset).
REQ-036 SHALL check a restart: load_start plus wr_valid in LOAD at wr_addr=4 -> no write at address 4, wr_addr=0, and the next word lands at address 0.
REQ-037 SHALL check a reload from RUN: load_start in RUN -> cpu_run=0 next cycle; wr_valid with wr_ready=0 causes no write.
REQ-038 SHALL check reset mid-LOAD: reset at wr_addr=5 -> IDLE, all mem=0, and run_start then gives cpu_run=1 with instr=0.
